// File: rtl/video_frame_gate.sv
// -----------------------------------------------------------------------------
// video_frame_gate
//
// Frame-structure sanitizer in front of the frame buffer write path. Locks onto
// start-of-frame (tuser), checks every line against FRAME_RES_X x FRAME_RES_Y,
// and repairs or discards malformed traffic so that downstream only sees lines
// that start on a frame boundary and end with tlast at the configured width.
//
// Optional feature macro: VIDEO_FRAME_GATE_PAD_EN
//   defined   -> short lines are zero-padded to FRAME_RES_X and an early SOF is
//                held until the current line has been padded out.
//   undefined -> short lines pass through short and are only flagged.
//
// Ports
//   clk_i, rst_n_i          single clock, async active-low reset
//   video_i_*               AXI4-Stream slave: raw pixels, tuser=SOF, tlast=EOL
//   video_o_*               AXI4-Stream master: sanitized pixels, one register
//                           stage, tstrb/tkeep tied to all ones
//   locked_o                high while a frame is being passed
//   err_stb_o / err_code_o  one-cycle error pulse; 0 SHORT, 1 LONG,
//                           2 EARLY_SOF, 3 EXTRA_LINE
//   err_cnt_o               saturating error count, cleared only by reset
// -----------------------------------------------------------------------------
module video_frame_gate #(
    parameter int FRAME_RES_X   = 1920,
    parameter int FRAME_RES_Y   = 1080,
    parameter int TDATA_WIDTH   = 16,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           video_i_tvalid,
    output logic                           video_i_tready,
    input  logic [TDATA_WIDTH-1:0]         video_i_tdata,
    input  logic [0:0]                     video_i_tuser,
    input  logic                           video_i_tlast,
    output logic                           video_o_tvalid,
    input  logic                           video_o_tready,
    output logic [TDATA_WIDTH-1:0]         video_o_tdata,
    output logic [(TDATA_WIDTH+7)/8-1:0]   video_o_tstrb,
    output logic [(TDATA_WIDTH+7)/8-1:0]   video_o_tkeep,
    output logic [0:0]                     video_o_tuser,
    output logic                           video_o_tlast,
    output logic                           locked_o,
    output logic                           err_stb_o,
    output logic [1:0]                     err_code_o,
    output logic [ERR_CNT_WIDTH-1:0]       err_cnt_o
);

`ifdef VIDEO_FRAME_GATE_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    localparam int KEEP_W = (TDATA_WIDTH + 7) / 8;
    localparam int XW     = $clog2(FRAME_RES_X);
    localparam int YW     = $clog2(FRAME_RES_Y);

    localparam logic [XW-1:0] X_LAST = XW'(FRAME_RES_X - 1);
    localparam logic [XW-1:0] X_ZERO = {XW{1'b0}};
    localparam logic [XW-1:0] X_ONE  = XW'(1'b1);
    localparam logic [YW-1:0] Y_LAST = YW'(FRAME_RES_Y - 1);
    localparam logic [YW-1:0] Y_ZERO = {YW{1'b0}};
    localparam logic [YW-1:0] Y_ONE  = YW'(1'b1);
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE = ERR_CNT_WIDTH'(1'b1);
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = {ERR_CNT_WIDTH{1'b1}};

    localparam logic [1:0] ERR_SHORT = 2'd0;
    localparam logic [1:0] ERR_LONG  = 2'd1;
    localparam logic [1:0] ERR_EARLY = 2'd2;
    localparam logic [1:0] ERR_EXTRA = 2'd3;

    typedef enum logic [1:0] {
        ST_WAIT_SOF = 2'd0,
        ST_PASS     = 2'd1,
        ST_PAD      = 2'd2,
        ST_DROP     = 2'd3
    } state_t;

    state_t                   state_r, state_nx_s, take_nx_s;
    logic [XW-1:0]            x_cnt_r, x_nx_s, eff_x_s;
    logic [YW-1:0]            y_cnt_r, y_nx_s, eff_y_s;
    logic                     frame_done_r, done_nx_s;   // last line closed a frame
    logic                     pad_to_sof_r, pad_sof_nx_s; // pad was caused by an early SOF
    logic                     out_valid_r, out_user_r, out_last_r;
    logic [TDATA_WIDTH-1:0]   out_data_r;
    logic                     locked_r, err_stb_r;
    logic [1:0]               err_code_r;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_r;

    logic is_sof_s, x_end_s, short_s, long_s, line_end_s, frame_end_s;
    logic early_s, hold_sof_s, can_load_s, gate_s, fire_s, take_s;
    logic hold_fire_s, pad_fire_s, pad_last_s;
    logic load_s, ld_user_s, ld_last_s, err_s;
    logic [TDATA_WIDTH-1:0] ld_data_s;
    logic [1:0]             err_code_s;

    // Beat decode: effective pixel position, line/frame end and handshake gating
    always_comb begin
        is_sof_s    = video_i_tuser[0];
        // An SOF beat always restarts the raster at (0,0)
        eff_x_s     = is_sof_s ? X_ZERO : x_cnt_r;
        eff_y_s     = is_sof_s ? Y_ZERO : y_cnt_r;
        x_end_s     = (eff_x_s == X_LAST);
        short_s     = video_i_tlast && !x_end_s;
        long_s      = x_end_s && !video_i_tlast;
        line_end_s  = PAD_EN ? x_end_s : (x_end_s || video_i_tlast);
        frame_end_s = line_end_s && (eff_y_s == Y_LAST);
        early_s     = is_sof_s && (state_r == ST_PASS) &&
                      ((x_cnt_r != X_ZERO) || (y_cnt_r != Y_ZERO));
        // With padding, a mid-line SOF stays on the input until the line is closed
        hold_sof_s  = PAD_EN && early_s && (x_cnt_r != X_ZERO);
        can_load_s  = !out_valid_r || video_o_tready;
        case (state_r)
            ST_WAIT_SOF: gate_s = 1'b1;
            ST_PASS:     gate_s = !hold_sof_s;
            ST_DROP:     gate_s = 1'b1;
            default:     gate_s = 1'b0;
        endcase
        video_i_tready = gate_s && can_load_s;
        fire_s         = video_i_tvalid && video_i_tready;
        take_s         = fire_s && ((state_r == ST_PASS) ||
                                    ((state_r == ST_WAIT_SOF) && is_sof_s));
        hold_fire_s    = video_i_tvalid && can_load_s && (state_r == ST_PASS) && hold_sof_s;
        pad_fire_s     = (state_r == ST_PAD) && can_load_s;
        pad_last_s     = (x_cnt_r == X_LAST);
        if (long_s) begin
            take_nx_s = ST_DROP;
        end else if (PAD_EN && short_s) begin
            take_nx_s = ST_PAD;
        end else if (frame_end_s) begin
            take_nx_s = ST_WAIT_SOF;
        end else begin
            take_nx_s = ST_PASS;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_WAIT_SOF: begin
                if (take_s) state_nx_s = take_nx_s;
                else        state_nx_s = ST_WAIT_SOF;
            end
            ST_PASS: begin
                if (hold_fire_s) state_nx_s = ST_PAD;
                else if (take_s) state_nx_s = take_nx_s;
                else             state_nx_s = ST_PASS;
            end
            ST_PAD: begin
                if (pad_fire_s && pad_last_s)
                    state_nx_s = (pad_to_sof_r || (y_cnt_r == Y_LAST)) ? ST_WAIT_SOF : ST_PASS;
                else
                    state_nx_s = ST_PAD;
            end
            ST_DROP: begin
                if (fire_s && video_i_tlast)
                    state_nx_s = frame_done_r ? ST_WAIT_SOF : ST_PASS;
                else
                    state_nx_s = ST_DROP;
            end
            default: state_nx_s = ST_WAIT_SOF;
        endcase
    end

    // FSM outputs: output-register load, counter update and error classification
    always_comb begin
        x_nx_s       = x_cnt_r;
        y_nx_s       = y_cnt_r;
        done_nx_s    = frame_done_r;
        pad_sof_nx_s = pad_to_sof_r;
        load_s       = 1'b0;
        ld_data_s    = {TDATA_WIDTH{1'b0}};
        ld_user_s    = 1'b0;
        ld_last_s    = 1'b0;
        err_s        = 1'b0;
        err_code_s   = ERR_SHORT;
        if (take_s) begin
            load_s       = 1'b1;
            ld_data_s    = video_i_tdata;
            ld_user_s    = (eff_x_s == X_ZERO) && (eff_y_s == Y_ZERO);
            ld_last_s    = line_end_s;
            x_nx_s       = line_end_s ? X_ZERO : eff_x_s + X_ONE;
            if (line_end_s) y_nx_s = (eff_y_s == Y_LAST) ? Y_ZERO : eff_y_s + Y_ONE;
            else            y_nx_s = eff_y_s;
            done_nx_s    = frame_end_s;
            pad_sof_nx_s = 1'b0;
            if (early_s) begin
                err_s = 1'b1; err_code_s = ERR_EARLY;
            end else if (short_s) begin
                err_s = 1'b1; err_code_s = ERR_SHORT;
            end else if (long_s) begin
                err_s = 1'b1; err_code_s = ERR_LONG;
            end else begin
                err_s = 1'b0;
            end
        end else if (hold_fire_s) begin
            err_s        = 1'b1;
            err_code_s   = ERR_EARLY;
            pad_sof_nx_s = 1'b1;
        end else if (pad_fire_s) begin
            load_s    = 1'b1;
            ld_last_s = pad_last_s;
            if (pad_last_s) begin
                x_nx_s = X_ZERO;
                if (pad_to_sof_r) begin
                    y_nx_s    = Y_ZERO;
                    done_nx_s = 1'b0;
                end else begin
                    y_nx_s    = (y_cnt_r == Y_LAST) ? Y_ZERO : y_cnt_r + Y_ONE;
                    done_nx_s = (y_cnt_r == Y_LAST);
                end
            end else begin
                x_nx_s = x_cnt_r + X_ONE;
            end
        end else if (fire_s && (state_r == ST_WAIT_SOF) && frame_done_r) begin
            // First stray beat after a completed frame; flagged once per gap
            err_s      = 1'b1;
            err_code_s = ERR_EXTRA;
            done_nx_s  = 1'b0;
        end else begin
            load_s = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_r <= ST_WAIT_SOF;
        else          state_r <= state_nx_s;
    end

    // Counters, output stage and status registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            x_cnt_r      <= X_ZERO;
            y_cnt_r      <= Y_ZERO;
            frame_done_r <= 1'b0;
            pad_to_sof_r <= 1'b0;
            out_valid_r  <= 1'b0;
            out_data_r   <= {TDATA_WIDTH{1'b0}};
            out_user_r   <= 1'b0;
            out_last_r   <= 1'b0;
            locked_r     <= 1'b0;
            err_stb_r    <= 1'b0;
            err_code_r   <= 2'd0;
            err_cnt_r    <= {ERR_CNT_WIDTH{1'b0}};
        end else begin
            x_cnt_r      <= x_nx_s;
            y_cnt_r      <= y_nx_s;
            frame_done_r <= done_nx_s;
            pad_to_sof_r <= pad_sof_nx_s;
            // Payload only changes on a load, so it stays stable under backpressure
            if (can_load_s) begin
                out_valid_r <= load_s;
                if (load_s) begin
                    out_data_r <= ld_data_s;
                    out_user_r <= ld_user_s;
                    out_last_r <= ld_last_s;
                end
            end
            locked_r  <= (state_nx_s != ST_WAIT_SOF);
            err_stb_r <= err_s;
            if (err_s) begin
                err_code_r <= err_code_s;
                if (err_cnt_r != CNT_MAX) err_cnt_r <= err_cnt_r + CNT_ONE;
            end
        end
    end

    assign video_o_tvalid   = out_valid_r;
    assign video_o_tdata    = out_data_r;
    assign video_o_tuser[0] = out_user_r;
    assign video_o_tlast    = out_last_r;
    assign video_o_tstrb    = {KEEP_W{1'b1}};
    assign video_o_tkeep    = {KEEP_W{1'b1}};
    assign locked_o         = locked_r;
    assign err_stb_o        = err_stb_r;
    assign err_code_o       = err_code_r;
    assign err_cnt_o        = err_cnt_r;

endmodule

// File: doc/video_frame_gate.md
# video_frame_gate

Frame-structure sanitizer placed directly upstream of the frame buffer write path, in the camera/input clock domain. It locks onto start-of-frame (`tuser`), checks every line against the configured `FRAME_RES_X` × `FRAME_RES_Y` geometry, and repairs or discards malformed traffic. The frame buffer therefore only ever receives lines that start on a frame boundary and end with `tlast` at the configured width. Status pulses and a saturating error counter are provided for debug/CSR readout.

## Interface
- `FRAME_RES_X`, 1920, pixels per line (≥2)
- `FRAME_RES_Y`, 1080, lines per frame (≥2)
- `TDATA_WIDTH`, 16, pixel width in bits
- `ERR_CNT_WIDTH`, 16, width of the error counter

Ports:
- `clk_i`  in  1  single clock
- `rst_n_i`  in  1  reset, asynchronous assert, active-low
- `video_i`  slave `axi4_stream_if`  `TDATA_WIDTH`, `TUSER_WIDTH`=1  raw pixel stream; `tuser`=SOF, `tlast`=EOL
- `video_o`  master `axi4_stream_if`  same widths  sanitized stream; `tstrb`/`tkeep` all ones
- `locked_o`  out  1  high while a frame is being passed
- `err_stb_o`  out  1  one-cycle pulse per detected error
- `err_code_o`  out  2  valid with `err_stb_o`: 0 SHORT, 1 LONG, 2 EARLY_SOF, 3 EXTRA_LINE
- `err_cnt_o`  out  `ERR_CNT_WIDTH`  saturating error count; cleared only by reset

## Operation
- Counters: `x_cnt` is `$clog2(FRAME_RES_X)` bits and `y_cnt` is `$clog2(FRAME_RES_Y)` bits.
  - `x_cnt` increments per accepted output pixel and wraps to 0 after `FRAME_RES_X-1`.
  - `y_cnt` increments on line end and wraps to 0 after `FRAME_RES_Y-1`.
- State machine:
  - WAIT_SOF: `video_i.tready`=1 and all beats are discarded. A beat with `tuser`=1 goes to PASS; that beat is forwarded as pixel (0,0).
  - PASS: beats are forwarded. `tuser` is forced to 1 only at (0,0). `tlast` is forced to 1 exactly at `x_cnt`=`FRAME_RES_X-1`.
  - PAD (`VIDEO_FRAME_GATE_PAD_EN` only): `video_i.tready`=0. Zero-data pixels are emitted until `x_cnt`=`FRAME_RES_X-1` (that pixel carries `tlast`=1), then the FSM returns to PASS or WAIT_SOF.
  - DROP_LINE: `video_i.tready`=1 and beats are discarded until an input `tlast`. Then go to PASS, or to WAIT_SOF if the frame is complete.
- After the last pixel of line `FRAME_RES_Y-1`, go to WAIT_SOF.
- Error rules (at most one error per beat; priority EARLY_SOF > SHORT > LONG):
  - EARLY_SOF: `tuser`=1 in PASS at (x,y)≠(0,0).
    - Without PAD: the beat is forwarded as a new (0,0) and counters restart.
    - With PAD and `x_cnt`≠0: the beat is held, the line is padded, then the SOF beat is taken in WAIT_SOF.
  - SHORT: input `tlast`=1 with `x_cnt`<`FRAME_RES_X-1`.
    - Without PAD: forwarded as a short line and `y_cnt` advances.
    - With PAD: go to PAD.
  - LONG: `x_cnt`=`FRAME_RES_X-1` and input `tlast`=0. The output gets `tlast`=1, then go to DROP_LINE.
  - EXTRA_LINE: the first non-SOF beat in WAIT_SOF after a completed frame. Flagged once per gap.
- `err_cnt_o` saturates at all ones.
- `locked_o` = (state≠WAIT_SOF).

## Timing
- Output is one register stage; latency is 1 cycle from input handshake to `video_o.tvalid`.
- `video_i.tready` = state-dependent gate AND (`!video_o.tvalid` || `video_o.tready`). Full throughput, no bubbles.
- `video_o` holds `tdata`, `tuser` and `tlast` stable while `tvalid`=1 and `tready`=0.
- `err_stb_o` and `err_code_o` are registered and assert in the cycle the offending beat appears on `video_o`, or the cycle it is discarded.
- Reset values:
  - `video_o.tvalid`=0, `locked_o`=0, `err_stb_o`=0, `err_code_o`=0, `err_cnt_o`=0.
  - State WAIT_SOF; both counters 0.
- Reset mid-frame: outputs drop immediately. After release, the block waits for the next SOF; the partial frame is never completed.

## Configuration
- `VIDEO_FRAME_GATE_PAD_EN` defined: the PAD state is compiled in.
  - Short lines are zero-padded to `FRAME_RES_X`.
  - Early SOF is held until the current line is padded.
  - Every output line is exactly `FRAME_RES_X` beats.
- Undefined: no PAD state. Short lines pass through short and are only flagged.

## Test plan
All scenarios use `FRAME_RES_X`=4, `FRAME_RES_Y`=3 and pixel data = running index.
- Clean frames, `video_o.tready` toggling 50%:
  - 2 frames out identical to input, with `tuser` at beats 0 and 12 and `tlast` every 4th beat.
  - `err_cnt_o`=0, no data loss.
- 5 garbage beats before the first SOF: all discarded, `err_cnt_o`=0, first output beat has `tuser`=1.
- Line 1 of 3 pixels (`tlast` on 3rd):
  - PAD: output line is 3 data pixels + 1 zero pixel with `tlast`; `err_code_o`=0 pulse.
  - No PAD: 3-pixel line out.
- Line 0 of 6 pixels: output `tlast` on pixel 4; pixels 5–6 dropped; `err_code_o`=1; next line starts at `x_cnt`=0.
- SOF at (2,1): `err_code_o`=2.
  - No PAD: new frame starts with that beat.
  - PAD: 2 zero pixels close the line, then the new frame starts.
- Extra 4th line after a complete frame: dropped, single `err_code_o`=3 pulse. Also: assert reset mid-line 1 → `video_o.tvalid` goes to 0 at once and output resumes only at the next SOF.
